uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader sitting directly downstream of `uart_unit`. Drives its byte-level handshake (`uart_go`/`rors`/`uart_done`), consumes received bytes, and writes little-endian 32-bit words into instruction memory. Sits between `uart_unit` and the imem write port. The core is held off until `load_done` rises.

## Interface
Parameters:
- `ADDR_W`, default 12: imem word-address width. Capacity is `2**ADDR_W` words.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Ignored while `busy`=1.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE or ERR is entered.
- `load_done`  out  1  level; load completed successfully. Cleared by the next accepted `start`.
- `load_err`  out  1  level; header word count exceeded capacity. Cleared by the next accepted `start`.
- `uart_go`  out  1  one-cycle pulse to `uart_unit` requesting one byte operation.
- `rors`  out  1  to `uart_unit`: 1 = receive, 0 = send. Held stable from `uart_go` until `uart_done`.
- `uart_done`  in  1  one-cycle pulse from `uart_unit`: byte operation finished. `rxdata` is valid in that cycle.
- `rxdata`  in  8  received byte.
- `txdata`  out  8  byte to send. Held stable from `uart_go` until `uart_done`.
- `imem_we`  out  1  imem write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  imem word address.
- `imem_wdata`  out  32  imem write data.

## Operation
Stream format: a 4-byte header N (word count, little-endian, 32 bits), followed by N words of 4 bytes each, little-endian (first byte → `[7:0]`).

States:
- IDLE: waits for `start`. On `start`, clears `byte_idx`, `word_cnt`, `load_done`, `load_err`, then goes to HDR_REQ.
- HDR_REQ: pulses `uart_go` with `rors`=1, then goes to HDR_WAIT.
- HDR_WAIT: on `uart_done`, shifts `rxdata` into the header register at lane `byte_idx`.
  - If `byte_idx`<3, increments it and returns to HDR_REQ.
  - Otherwise evaluates N:
    - N > `2**ADDR_W` → ERR.
    - N == 0 → FIN.
    - Else → DAT_REQ.
- DAT_REQ / DAT_WAIT: same byte handshake as the header states; bytes fill `imem_wdata` lanes. After the 4th byte, goes to WRITE.
- WRITE: `imem_we`=1 for exactly one cycle, `imem_addr`=`word_cnt`, `imem_wdata`=assembled word. Then `word_cnt`++.
  - If `word_cnt`+1 == N → FIN.
  - Else → DAT_REQ.
- FIN: → ACK_REQ if `LOADER_ECHO_EN` is defined, else DONE.
- DONE: `load_done`=1. Returns to IDLE behaviour: a new `start` is accepted.
- ERR: `load_err`=1. No further UART requests. A new `start` is accepted.

Counters and widths:
- `word_cnt` is ADDR_W+1 bits wide, so N == `2**ADDR_W` is legal (fills memory exactly).
- Comparison against N uses the full 32 bits.

Invariants:
- Never more than one outstanding `uart_go`. The next `uart_go` is issued no earlier than the cycle after `uart_done`.
- `uart_done` arriving in any state other than a *_WAIT state is ignored.

Reset:
- Asserting `rstn` mid-load returns to IDLE immediately.
- No partial word is written.

## Timing
Reset values:
- `busy`, `load_done`, `load_err`, `uart_go`, `imem_we` = 0.
- `rors` = 1.
- `txdata`, `imem_addr`, `imem_wdata` = 0.

Cycle timing:
- `start` at cycle t → `uart_go` at t+1 (HDR_REQ registered), `busy` at t+1.
- `uart_done` at cycle u → next `uart_go` at u+1. For the 4th data byte, `imem_we` at u+1 instead, and the next `uart_go` at u+2.
- Last word: `imem_we` at w → `load_done` and `busy`=0 at w+2 without echo (FIN then DONE).
- All outputs are registered.

## Configuration
- `LOADER_ECHO_EN` defined:
  - FIN → ACK_REQ: pulses `uart_go` with `rors`=0 and `txdata`=8'hAA.
  - ACK_WAIT: waits for `uart_done`, then → DONE.
  - ERR also sends one byte, 8'hEE, before settling.
- `LOADER_ECHO_EN` undefined:
  - No send is ever issued. `rors` stays 1 and `txdata` stays 0.
  - FIN → DONE directly.

## Test plan
- Header `02 00 00 00`, data `44 33 22 11 DD CC BB AA` → `imem_we` twice: addr 0 = 0x11223344, addr 1 = 0xAABBCCDD. Then `load_done`=1 and `busy`=0.
- Header `00 00 00 00` → no `imem_we`. `load_done`=1 after the 4th `uart_done`. Exactly 4 `uart_go` pulses (5 with echo).
- `ADDR_W`=2, header `05 00 00 00` → `load_err`=1, `load_done`=0, no `imem_we`, no further `uart_go` (one send of 0xEE with echo). `ADDR_W`=2 with N=4 → 4 writes at addr 0..3, `load_done`=1.
- `rstn` low after 2 data bytes, then `start` again with header `01 00 00 00`, data `78 56 34 12` → single write addr 0 = 0x12345678. Stale bytes are not merged.
- `start` pulsed while `busy`, plus a spurious `uart_done` during HDR_REQ → both ignored. Byte count and addresses unchanged.
- With `LOADER_ECHO_EN`: after the last write, one `uart_go` with `rors`=0 and `txdata`=0xAA. `load_done` rises the cycle after that send's `uart_done`.

Source files
------------

// File: rtl/uart_loader.sv
// Boot-time loader: pulls a word-count header plus little-endian words from uart_unit
// and writes them into instruction memory. Optional LOADER_ECHO_EN sends an ack/error byte.
module uart_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              uart_go,
  output logic              rors,
  input  logic              uart_done,
  input  logic [7:0]        rxdata,
  output logic [7:0]        txdata,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata
);

  typedef enum logic [3:0] {
    StIdle, StHdrReq, StHdrWait, StDatReq, StDatWait, StWrite, StFin,
    StAckReq, StAckWait, StDone, StErr, StErrReq, StErrWait
  } state_e;

  // One past the last word address; N equal to this fills memory exactly.
  localparam logic [32:0] Cap = 33'd1 << ADDR_W;

  state_e          state;
  logic [1:0]      byte_idx;
  logic [ADDR_W:0] word_cnt;
  logic [31:0]     hdr;
  logic [23:0]     word;
  logic [31:0]     hdr_full;
  logic [32:0]     cnt_next;

  assign hdr_full = {rxdata, hdr[23:0]};
  assign cnt_next = 33'(word_cnt) + 33'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= StIdle;
      byte_idx   <= '0;
      word_cnt   <= '0;
      hdr        <= '0;
      word       <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      uart_go    <= 1'b0;
      rors       <= 1'b1;
      txdata     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      uart_go <= 1'b0;
      imem_we <= 1'b0;
      case (state)
        StIdle, StDone, StErr: begin
          if (start) begin
            byte_idx  <= '0;
            word_cnt  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            busy      <= 1'b1;
            uart_go   <= 1'b1;
            rors      <= 1'b1;
            state     <= StHdrReq;
          end
        end
        StHdrReq: state <= StHdrWait;
        StHdrWait: begin
          if (uart_done) begin
            hdr[{byte_idx, 3'b000} +: 8] <= rxdata;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3) begin
              uart_go <= 1'b1;
              state   <= StHdrReq;
            end else if ({1'b0, hdr_full} > Cap) begin
              load_err <= 1'b1;
              busy     <= 1'b0;
`ifdef LOADER_ECHO_EN
              uart_go  <= 1'b1;
              rors     <= 1'b0;
              txdata   <= 8'hEE;
              state    <= StErrReq;
`else
              state    <= StErr;
`endif
            end else if (hdr_full == 32'd0) begin
              state <= StFin;
            end else begin
              uart_go <= 1'b1;
              state   <= StDatReq;
            end
          end
        end
        StDatReq: state <= StDatWait;
        StDatWait: begin
          if (uart_done) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0:    word[7:0]   <= rxdata;
              2'd1:    word[15:8]  <= rxdata;
              2'd2:    word[23:16] <= rxdata;
              default: ;
            endcase
            if (byte_idx != 2'd3) begin
              uart_go <= 1'b1;
              state   <= StDatReq;
            end else begin
              imem_we    <= 1'b1;
              imem_addr  <= word_cnt[ADDR_W-1:0];
              imem_wdata <= {rxdata, word};
              state      <= StWrite;
            end
          end
        end
        StWrite: begin
          word_cnt <= word_cnt + 1'b1;
          if (cnt_next == {1'b0, hdr}) begin
            state <= StFin;
          end else begin
            uart_go <= 1'b1;
            state   <= StDatReq;
          end
        end
        StFin: begin
`ifdef LOADER_ECHO_EN
          uart_go <= 1'b1;
          rors    <= 1'b0;
          txdata  <= 8'hAA;
          state   <= StAckReq;
`else
          load_done <= 1'b1;
          busy      <= 1'b0;
          state     <= StDone;
`endif
        end
`ifdef LOADER_ECHO_EN
        StAckReq: state <= StAckWait;
        StAckWait: begin
          if (uart_done) begin
            load_done <= 1'b1;
            busy      <= 1'b0;
            rors      <= 1'b1;
            state     <= StDone;
          end
        end
        StErrReq: state <= StErrWait;
        StErrWait: begin
          if (uart_done) begin
            rors  <= 1'b1;
            state <= StErr;
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: a UART byte responder feeds directed streams and a
// monitor pops expected imem writes. Honours LOADER_ECHO_EN when defined.
module tb_uart_loader;
  localparam int unsigned AW = 2;
`ifdef LOADER_ECHO_EN
  localparam int EchoN = 1;
`else
  localparam int EchoN = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          busy, load_done, load_err, uart_go, rors, imem_we;
  logic [7:0]    txdata;
  logic [7:0]    rxdata = 8'h00;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          resp_done = 1'b0;
  logic          spur_done = 1'b0;
  wire logic     uart_done = resp_done | spur_done;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int go_cnt = 0, done_cnt = 0;
  int last_we_cyc = 0, last_done_cyc = 0, done_cyc = 0;
  logic [7:0]    rx_q[$];
  logic [7:0]    sends[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            pend = 1'b0;
  int            dly = 0;
  logic [7:0]    pend_byte = 8'h00;

  uart_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .load_done(load_done),
    .load_err(load_err), .uart_go(uart_go), .rors(rors), .uart_done(uart_done),
    .rxdata(rxdata), .txdata(txdata), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic exp_write(input logic [AW-1:0] a, input logic [31:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int max);
    int k = 0;
    while (!(load_done || load_err) && k < max) begin
      @(negedge clk);
      k++;
    end
    if (!(load_done || load_err)) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no completion want done/err within %0d cycles", name, max);
    end
    done_cyc = cyc;
  endtask

  // UART responder plus imem scoreboard monitor, all sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    resp_done = 1'b0;
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (dly == 0) begin
          rxdata        = pend_byte;
          resp_done     = 1'b1;
          done_cnt++;
          last_done_cyc = cyc;
          pend          = 1'b0;
        end else begin
          dly--;
        end
      end
      if (uart_go) begin
        go_cnt++;
        chk("one_outstanding", 32'(pend), 32'd0);
`ifndef LOADER_ECHO_EN
        chk("go_rors_recv", 32'(rors), 32'd1);
        chk("go_txdata_zero", 32'(txdata), 32'd0);
`endif
        pend_byte = 8'h00;
        if (rors) begin
          if (rx_q.size() > 0) pend_byte = rx_q.pop_front();
        end else begin
          sends.push_back(txdata);
        end
        pend = 1'b1;
        dly  = 1;
      end
      if (imem_we) begin
        last_we_cyc = cyc;
        if (exp_addr.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %h want none", imem_addr, imem_wdata);
        end else begin
          chk("write_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
          chk("write_data", imem_wdata, exp_data.pop_front());
        end
      end
    end
  end

  initial begin
    int g0, d0, k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_uart_go", 32'(uart_go), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_rors", 32'(rors), 32'd1);
    chk("rst_txdata", 32'(txdata), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    rstn = 1'b1;

    // Two words, header 02 00 00 00
    push_word(32'd2); push_word(32'h11223344); push_word(32'hAABBCCDD);
    exp_write(2'd0, 32'h11223344); exp_write(2'd1, 32'hAABBCCDD);
    g0 = go_cnt;
    do_start();
    chk("t1_busy_t1", 32'(busy), 32'd1);
    chk("t1_go_t1", 32'(uart_go), 32'd1);
    wait_end("t1", 400);
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_load_err", 32'(load_err), 32'd0);
    chk("t1_go_count", 32'(go_cnt - g0), 32'(12 + EchoN));
    chk("t1_writes_left", 32'(exp_addr.size()), 32'd0);
`ifdef LOADER_ECHO_EN
    chk("t1_ack_count", 32'(sends.size()), 32'd1);
    chk("t1_ack_byte", 32'((sends.size() > 0) ? sends[0] : 8'h00), 32'hAA);
    chk("t1_ack_latency", 32'(done_cyc - last_done_cyc), 32'd1);
    sends.delete();
`else
    chk("t1_done_latency", 32'(done_cyc - last_we_cyc), 32'd2);
`endif

    // Empty image
    push_word(32'd0);
    g0 = go_cnt;
    do_start();
    wait_end("t2", 200);
    chk("t2_load_done", 32'(load_done), 32'd1);
    chk("t2_load_err", 32'(load_err), 32'd0);
    chk("t2_go_count", 32'(go_cnt - g0), 32'(4 + EchoN));
`ifdef LOADER_ECHO_EN
    chk("t2_ack_byte", 32'((sends.size() > 0) ? sends[0] : 8'h00), 32'hAA);
    sends.delete();
`endif

    // Oversize header: 5 words into a 4-word memory
    push_word(32'd5);
    g0 = go_cnt;
    do_start();
    wait_end("t3", 200);
    repeat (20) @(negedge clk);
    chk("t3_load_err", 32'(load_err), 32'd1);
    chk("t3_load_done", 32'(load_done), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_go_count", 32'(go_cnt - g0), 32'(4 + EchoN));
`ifdef LOADER_ECHO_EN
    chk("t3_err_byte", 32'((sends.size() > 0) ? sends[0] : 8'h00), 32'hEE);
    sends.delete();
`endif

    // Exactly full memory
    push_word(32'd4);
    push_word(32'hA3A2A1A0); push_word(32'hB3B2B1B0);
    push_word(32'hC3C2C1C0); push_word(32'hD3D2D1D0);
    exp_write(2'd0, 32'hA3A2A1A0); exp_write(2'd1, 32'hB3B2B1B0);
    exp_write(2'd2, 32'hC3C2C1C0); exp_write(2'd3, 32'hD3D2D1D0);
    g0 = go_cnt;
    do_start();
    wait_end("t4", 600);
    chk("t4_load_done", 32'(load_done), 32'd1);
    chk("t4_load_err", 32'(load_err), 32'd0);
    chk("t4_go_count", 32'(go_cnt - g0), 32'(20 + EchoN));
    chk("t4_writes_left", 32'(exp_addr.size()), 32'd0);
`ifdef LOADER_ECHO_EN
    sends.delete();
`endif

    // Upper header byte set: must not alias to a small count
    push_word(32'h01000004);
    do_start();
    wait_end("t5", 200);
    repeat (20) @(negedge clk);
    chk("t5_load_err", 32'(load_err), 32'd1);
    chk("t5_load_done", 32'(load_done), 32'd0);
`ifdef LOADER_ECHO_EN
    sends.delete();
`endif

    // Reset after two data bytes, then a clean single-word load
    push_word(32'd3); push_word(32'hCAFEF00D);
    d0 = done_cnt;
    do_start();
    k = 0;
    while (done_cnt - d0 < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_bytes_before_reset", 32'(done_cnt - d0), 32'd6);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_go", 32'(uart_go), 32'd0);
    chk("t6_rst_we", 32'(imem_we), 32'd0);
    rx_q.delete();
    rstn = 1'b1;
    push_word(32'd1); push_word(32'h12345678);
    exp_write(2'd0, 32'h12345678);
    do_start();
    wait_end("t6", 300);
    chk("t6_load_done", 32'(load_done), 32'd1);
    chk("t6_writes_left", 32'(exp_addr.size()), 32'd0);
`ifdef LOADER_ECHO_EN
    sends.delete();
`endif

    // Spurious uart_done in HDR_REQ and a start while busy are both ignored
    push_word(32'd1); push_word(32'h0BADBEEF);
    exp_write(2'd0, 32'h0BADBEEF);
    g0 = go_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("t7_busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_end("t7", 300);
    chk("t7_load_done", 32'(load_done), 32'd1);
    chk("t7_load_err", 32'(load_err), 32'd0);
    chk("t7_go_count", 32'(go_cnt - g0), 32'(8 + EchoN));
    chk("t7_writes_left", 32'(exp_addr.size()), 32'd0);

`ifndef LOADER_ECHO_EN
    chk("no_sends", 32'(sends.size()), 32'd0);
`endif
    chk("rx_consumed", 32'(rx_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
